// File: rtl/mm_port_arbiter.sv
// Arbitrates the single main-memory port between the I-cache refill path and the
// data-memory path. Uses round-robin on conflict, a fixed-latency sequencer and saturating stats.
module mm_port_arbiter #(
  parameter int MM_LATENCY = 4,
  parameter int CNT_W      = 20
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             I_Req,
  input  logic [31:0]      I_Addr,
  output logic             I_Ready,
  output logic [63:0]      I_Data,
  input  logic             D_Req,
  input  logic             D_Write,
  input  logic [31:0]      D_Addr,
  input  logic [31:0]      D_WData,
  output logic             D_Ready,
  output logic [31:0]      D_RData,
  output logic             MM_Access,
  output logic             MM_Write,
  output logic [31:0]      MM_Addr,
  output logic [31:0]      MM_WData,
  output logic             MM_WSel,
  input  logic [63:0]      MM_RData,
  output logic [1:0]       Grant,
  output logic [CNT_W-1:0] CNT_I,
  output logic [CNT_W-1:0] CNT_D,
  output logic [CNT_W-1:0] CNT_CONFLICT
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_I_BUSY = 2'd1;
  localparam logic [1:0] S_D_BUSY = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  localparam logic [3:0] WAIT_INIT = 4'(MM_LATENCY - 1);

  logic [1:0]       state;
  logic             resp_i;
  logic             last_d;
  logic [3:0]       wait_cnt;
  logic [31:0]      addr_q;
  logic             write_q;
  logic [31:0]      wdata_q;
  logic             wsel_q;
  logic [63:0]      i_data_q;
  logic [31:0]      d_rdata_q;
  logic [CNT_W-1:0] cnt_i;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_c;
  logic             pick_i;
  logic             unused_addr_bits;

  assign unused_addr_bits = ^{I_Addr[2:0], D_Addr[1:0]};

  // On a tie the side that did not win last time gets the port.
  assign pick_i = I_Req & (~D_Req | last_d);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state     <= S_IDLE;
      resp_i    <= 1'b0;
      last_d    <= 1'b1;
      wait_cnt  <= '0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      wsel_q    <= 1'b0;
      i_data_q  <= '0;
      d_rdata_q <= '0;
      cnt_i     <= '0;
      cnt_d     <= '0;
      cnt_c     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (I_Req || D_Req) begin
            state    <= pick_i ? S_I_BUSY : S_D_BUSY;
            resp_i   <= pick_i;
            last_d   <= ~pick_i;
            wait_cnt <= WAIT_INIT;
            addr_q   <= {(pick_i ? I_Addr[31:3] : D_Addr[31:3]), 3'b000};
            write_q  <= D_Write;
            wdata_q  <= D_WData;
            wsel_q   <= D_Addr[2];
            if (pick_i) cnt_i <= sat_inc(cnt_i);
            else        cnt_d <= sat_inc(cnt_d);
            if (I_Req && D_Req) cnt_c <= sat_inc(cnt_c);
          end
        end
        S_I_BUSY, S_D_BUSY: begin
          if (wait_cnt == 4'd0) begin
            state <= S_RESP;
            if (state == S_I_BUSY) i_data_q <= MM_RData;
            else if (!write_q)     d_rdata_q <= wsel_q ? MM_RData[63:32] : MM_RData[31:0];
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Handshake outputs decode straight from state so an async reset drops them at once.
  assign MM_Access    = (state == S_I_BUSY) || (state == S_D_BUSY);
  assign MM_Write     = (state == S_D_BUSY) && write_q;
  assign Grant        = {state == S_D_BUSY, state == S_I_BUSY};
  assign I_Ready      = (state == S_RESP) && resp_i;
  assign D_Ready      = (state == S_RESP) && !resp_i;
  assign MM_Addr      = addr_q;
  assign MM_WData     = wdata_q;
  assign MM_WSel      = wsel_q;
  assign I_Data       = i_data_q;
  assign D_RData      = d_rdata_q;
  assign CNT_I        = cnt_i;
  assign CNT_D        = cnt_d;
  assign CNT_CONFLICT = cnt_c;

endmodule
